spmv_csr_fetch: RTL and testbench

CSR operand fetch stage sitting directly upstream of `SpMV_core`. On a start pulse it loads the 17-entry row-pointer array from pointer RAM and assembles `row_ptr`. It then walks the non-zeros in order, reading each value and column index, then the matching vector element. It presents each FP16 pair to the core with an incrementing element count, at a fixed pacing the core consumes.

---
 rtl/spmv_csr_fetch.sv | 185 ++++++++++++++++++
 tb/tb_spmv_csr_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_csr_fetch.sv
// rtl/spmv_csr_fetch.sv - CSR operand fetch stage feeding FP16 pairs to the SpMV core
module spmv_csr_fetch #(
    parameter int ELEM_CYCLES = 7
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_start,
    output logic         o_ptr_rd,
    output logic [4:0]   o_ptr_addr,
    input  logic [7:0]   i_ptr_data,
    output logic         o_val_rd,
    output logic [7:0]   o_val_addr,
    input  logic [15:0]  i_val_data,
    input  logic [3:0]   i_col_data,
    output logic         o_vec_rd,
    output logic [3:0]   o_vec_addr,
    input  logic [15:0]  i_vec_data,
    output logic [15:0]  o_read_data_A,
    output logic [15:0]  o_read_data_B,
    output logic [7:0]   o_count,
    output logic [135:0] o_row_ptr,
    output logic         o_core_start,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_PTR, S_FA, S_FX, S_FB, S_HOLD, S_DONE
    } state_e;

    // HOLD lasts ELEM_CYCLES-3 cycles; the counter runs down to zero inclusive.
    localparam logic [7:0] HOLD_INIT = (ELEM_CYCLES > 3) ? 8'(ELEM_CYCLES - 4) : 8'd0;

    state_e         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [7:0]     count_q, count_d;
    logic [7:0]     hold_q, hold_d;
    logic [15:0]    a_q, a_d;
    logic [15:0]    data_a_q, data_a_d;
    logic [15:0]    data_b_q, data_b_d;
    logic [135:0]   row_ptr_q, row_ptr_d;
    logic           bad_q, bad_d;
    logic           err_q, err_d;
    logic           core_start_q, core_start_d;

    logic [4:0]     cap_idx;
    logic [4:0]     prev_idx;
    logic [7:0]     prev_ptr;
    logic [7:0]     nnz;

    // Pointer byte returning this cycle belongs to the address issued one cycle earlier.
    assign cap_idx  = idx_q - 5'd1;
    assign prev_idx = idx_q - 5'd2;
    assign prev_ptr = 8'(row_ptr_q >> {prev_idx, 3'b000});
    assign nnz      = row_ptr_q[135:128];

    assign o_read_data_A = data_a_q;
    assign o_read_data_B = data_b_q;
    assign o_count       = count_q;
    assign o_row_ptr     = row_ptr_q;
    assign o_core_start  = core_start_q;
    assign o_err         = err_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        count_d      = count_q;
        hold_d       = hold_q;
        a_d          = a_q;
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        row_ptr_d    = row_ptr_q;
        bad_d        = bad_q;
        err_d        = err_q;
        core_start_d = 1'b0;
        o_ptr_rd     = 1'b0;
        o_ptr_addr   = '0;
        o_val_rd     = 1'b0;
        o_val_addr   = '0;
        o_vec_rd     = 1'b0;
        o_vec_addr   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    count_d   = '0;
                    data_a_d  = '0;
                    data_b_d  = '0;
                    row_ptr_d = '0;
                    err_d     = 1'b0;
                    bad_d     = 1'b0;
                    idx_d     = '0;
                    state_d   = S_LOAD_PTR;
                end
            end
            S_LOAD_PTR: begin
                if (idx_q <= 5'd16) begin
                    o_ptr_rd   = 1'b1;
                    o_ptr_addr = idx_q;
                end
                if (idx_q != 5'd0) begin
                    row_ptr_d = row_ptr_q | (136'(i_ptr_data) << {cap_idx, 3'b000});
                    if ((idx_q >= 5'd2) && (i_ptr_data < prev_ptr)) begin
                        bad_d = 1'b1;
                    end
                end
                idx_d = idx_q + 5'd1;
                if (idx_q == 5'd17) begin
                    if (bad_d) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        core_start_d = 1'b1;
                        state_d      = (i_ptr_data == 8'd0) ? S_DONE : S_FA;
                    end
                end
            end
            S_FA: begin
                // count_q doubles as k: elements presented so far.
                o_val_rd   = 1'b1;
                o_val_addr = count_q;
                state_d    = S_FX;
            end
            S_FX: begin
                a_d        = i_val_data;
                o_vec_rd   = 1'b1;
                o_vec_addr = i_col_data;
                state_d    = S_FB;
            end
            S_FB: begin
                data_a_d = a_q;
                data_b_d = i_vec_data;
                count_d  = count_q + 8'd1;
                if (ELEM_CYCLES > 3) begin
                    hold_d  = HOLD_INIT;
                    state_d = S_HOLD;
                end else begin
                    state_d = (count_d == nnz) ? S_DONE : S_FA;
                end
            end
            S_HOLD: begin
                if (hold_q == 8'd0) begin
                    state_d = (count_q == nnz) ? S_DONE : S_FA;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            count_q      <= '0;
            hold_q       <= '0;
            a_q          <= '0;
            data_a_q     <= '0;
            data_b_q     <= '0;
            row_ptr_q    <= '0;
            bad_q        <= 1'b0;
            err_q        <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            a_q          <= a_d;
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            row_ptr_q    <= row_ptr_d;
            bad_q        <= bad_d;
            err_q        <= err_d;
            core_start_q <= core_start_d;
        end
    end
endmodule

// File: tb/tb_spmv_csr_fetch.sv
// tb/tb_spmv_csr_fetch.sv - timeline-model bench for spmv_csr_fetch at two pacings
module tb_spmv_csr_fetch;
    typedef struct packed {
        logic         busy;
        logic         done;
        logic         core_start;
        logic         err;
        logic         ptr_rd;
        logic [4:0]   ptr_addr;
        logic         val_rd;
        logic [7:0]   val_addr;
        logic         vec_rd;
        logic [3:0]   vec_addr;
        logic [7:0]   count;
        logic [15:0]  a;
        logic [15:0]  b;
        logic [135:0] row_ptr;
    } obs_t;

    logic        clk;
    logic        rstn;
    logic [1:0]  start_v;
    obs_t        obs [2];

    logic [7:0]  ptr_mem [32];
    logic [15:0] val_mem [256];
    logic [3:0]  col_mem [256];
    logic [15:0] vec_mem [16];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int start_cyc = 0;
    int sel    = 0;
    int ecur   = 7;
    int nnz_m  = 0;
    int done_m = 0;
    bit bad_m  = 0;
    bit checking = 0;
    int done_rel;
    int cmp_rel;
    obs_t cmp_e;
    obs_t cmp_a;
    logic [135:0] nom_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0]   ptr_data;
        logic [15:0]  val_data;
        logic [3:0]   col_data;
        logic [15:0]  vec_data;
        logic         ptr_rd, val_rd, vec_rd, core_start, busy, done, err;
        logic [4:0]   ptr_addr;
        logic [7:0]   val_addr, count;
        logic [3:0]   vec_addr;
        logic [15:0]  da, db;
        logic [135:0] row_ptr;

        spmv_csr_fetch #(.ELEM_CYCLES(g == 0 ? 7 : 3)) u_dut (
            .i_clk(clk), .i_rstn(rstn), .i_start(start_v[g]),
            .o_ptr_rd(ptr_rd), .o_ptr_addr(ptr_addr), .i_ptr_data(ptr_data),
            .o_val_rd(val_rd), .o_val_addr(val_addr), .i_val_data(val_data),
            .i_col_data(col_data), .o_vec_rd(vec_rd), .o_vec_addr(vec_addr),
            .i_vec_data(vec_data), .o_read_data_A(da), .o_read_data_B(db),
            .o_count(count), .o_row_ptr(row_ptr), .o_core_start(core_start),
            .o_busy(busy), .o_done(done), .o_err(err)
        );

        always @(posedge clk) begin
            if (ptr_rd) ptr_data <= ptr_mem[ptr_addr];
            if (val_rd) begin
                val_data <= val_mem[val_addr];
                col_data <= col_mem[val_addr];
            end
            if (vec_rd) vec_data <= vec_mem[vec_addr];
        end

        assign obs[g] = {busy, done, core_start, err, ptr_rd, ptr_addr, val_rd, val_addr,
                         vec_rd, vec_addr, count, da, db, row_ptr};
    end

    task automatic chk(input string name, input int rel, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s rel=%0d got %0h want %0h", name, rel, act, exp);
        else passed++;
    endtask

    // Expected outputs in cycle c after start, straight from the published timeline.
    function automatic obs_t model(input int c);
        obs_t e;
        e = '0;
        e.busy       = (c >= 1) && (c <= done_m);
        e.done       = (c == done_m);
        e.core_start = (c == 19) && !bad_m;
        e.err        = bad_m && (c >= 19);
        if (c >= 1 && c <= 17) begin
            e.ptr_rd   = 1'b1;
            e.ptr_addr = 5'(c - 1);
        end
        for (int j = 0; j < 17; j++) if (c >= j + 3) e.row_ptr[8*j +: 8] = ptr_mem[j];
        if (!bad_m) begin
            for (int k = 0; k < nnz_m; k++) begin
                if (c == 19 + k*ecur) begin e.val_rd = 1'b1; e.val_addr = 8'(k); end
                if (c == 20 + k*ecur) begin e.vec_rd = 1'b1; e.vec_addr = col_mem[k]; end
                if (c >= 22 + k*ecur) begin
                    e.count = 8'(k + 1);
                    e.a     = val_mem[k];
                    e.b     = vec_mem[col_mem[k]];
                end
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            cmp_rel = cyc - start_cyc;
            if (cmp_rel >= 1) begin
                cmp_e = model(cmp_rel);
                cmp_a = obs[sel];
                chk("busy",       cmp_rel, 256'(cmp_a.busy),       256'(cmp_e.busy));
                chk("done",       cmp_rel, 256'(cmp_a.done),       256'(cmp_e.done));
                chk("core_start", cmp_rel, 256'(cmp_a.core_start), 256'(cmp_e.core_start));
                chk("err",        cmp_rel, 256'(cmp_a.err),        256'(cmp_e.err));
                chk("ptr_rd",     cmp_rel, 256'(cmp_a.ptr_rd),     256'(cmp_e.ptr_rd));
                chk("ptr_addr",   cmp_rel, 256'(cmp_a.ptr_addr),   256'(cmp_e.ptr_addr));
                chk("val_rd",     cmp_rel, 256'(cmp_a.val_rd),     256'(cmp_e.val_rd));
                chk("val_addr",   cmp_rel, 256'(cmp_a.val_addr),   256'(cmp_e.val_addr));
                chk("vec_rd",     cmp_rel, 256'(cmp_a.vec_rd),     256'(cmp_e.vec_rd));
                chk("vec_addr",   cmp_rel, 256'(cmp_a.vec_addr),   256'(cmp_e.vec_addr));
                chk("count",      cmp_rel, 256'(cmp_a.count),      256'(cmp_e.count));
                chk("data_a",     cmp_rel, 256'(cmp_a.a),          256'(cmp_e.a));
                chk("data_b",     cmp_rel, 256'(cmp_a.b),          256'(cmp_e.b));
                chk("row_ptr",    cmp_rel, 256'(cmp_a.row_ptr),    256'(cmp_e.row_ptr));
            end
        end
    end

    task automatic setup_model(input int s);
        sel   = s;
        ecur  = (s == 0) ? 7 : 3;
        bad_m = 1'b0;
        for (int j = 1; j < 17; j++) if (ptr_mem[j] < ptr_mem[j-1]) bad_m = 1'b1;
        nnz_m  = int'(ptr_mem[16]);
        done_m = (bad_m || nnz_m == 0) ? 19 : 22 + (nnz_m - 1)*ecur + ecur - 3;
    endtask

    task automatic run(input int s, input bit poke);
        @(negedge clk);
        setup_model(s);
        start_cyc  = cyc;
        start_v[s] = 1'b1;
        checking   = 1'b1;
        done_rel   = -1;
        for (int i = 1; i <= 3000 && done_rel < 0; i++) begin
            @(negedge clk);
            start_v[s] = poke && (i >= 30) && (i <= 32);
            if (obs[s].done) done_rel = i;
        end
        chk("done_cycle", done_rel, 256'(done_rel), 256'(done_m));
        repeat (2) @(negedge clk);
        checking = 1'b0;
    endtask

    task automatic load_nominal();
        nom_ptr = 136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00;
        for (int j = 0; j < 32; j++) ptr_mem[j] = (j < 17) ? nom_ptr[8*j +: 8] : 8'h00;
        for (int k = 0; k < 256; k++) begin
            val_mem[k] = 16'h4C00;
            col_mem[k] = 4'(k);
        end
        for (int i = 0; i < 16; i++) vec_mem[i] = 16'h4000;
    endtask

    initial begin
        rstn    = 1'b0;
        start_v = 2'b00;
        load_nominal();
        repeat (3) @(negedge clk);
        chk("reset_state_e7", -1, 256'(obs[0]), 256'(0));
        chk("reset_state_e3", -1, 256'(obs[1]), 256'(0));
        rstn = 1'b1;

        // Nominal run with a start re-asserted mid-run.
        run(0, 1'b1);
        chk("nom_row_ptr", -1, 256'(obs[0].row_ptr),
            256'(136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00));
        chk("nom_count", -1, 256'(obs[0].count), 256'(8'd10));
        chk("nom_a",     -1, 256'(obs[0].a),     256'(16'h4C00));
        chk("nom_b",     -1, 256'(obs[0].b),     256'(16'h4000));
        chk("nom_done",  -1, 256'(done_rel),     256'(89));

        // Reset asserted in FX of element 1 (cycle 27), then a clean rerun.
        @(negedge clk);
        setup_model(0);
        start_cyc  = cyc;
        start_v[0] = 1'b1;
        checking   = 1'b1;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        chk("pre_abort_vec_rd", 27, 256'(obs[0].vec_rd), 256'(1));
        checking = 1'b0;
        rstn = 1'b0;
        #1;
        chk("abort_clears", 27, 256'(obs[0]), 256'(0));
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", i, 256'(obs[0].done), 256'(0));
        end
        run(0, 1'b0);
        chk("rerun_count", -1, 256'(obs[0].count), 256'(8'd10));

        // Column gather: 16 elements, col[k] = 15-k.
        for (int j = 0; j < 17; j++) ptr_mem[j] = 8'(j);
        for (int k = 0; k < 16; k++) begin
            val_mem[k] = 16'h3C00 + 16'(k);
            col_mem[k] = 4'(15 - k);
        end
        for (int i = 0; i < 16; i++) vec_mem[i] = 16'h1000 + 16'(i) * 16'h0111;
        run(0, 1'b0);
        chk("gather_count", -1, 256'(obs[0].count), 256'(8'd16));
        chk("gather_a",     -1, 256'(obs[0].a),     256'(16'h3C0F));
        chk("gather_b",     -1, 256'(obs[0].b),     256'(16'h1000));

        // nnz = 0.
        for (int j = 0; j < 17; j++) ptr_mem[j] = 8'h00;
        run(0, 1'b0);
        chk("nnz0_done",  -1, 256'(done_rel),     256'(19));
        chk("nnz0_count", -1, 256'(obs[0].count), 256'(0));

        // Non-monotonic: ptr[5] = 3 after ptr[4] = 4.
        for (int j = 0; j < 17; j++) ptr_mem[j] = 8'(j);
        ptr_mem[5] = 8'h03;
        run(0, 1'b0);
        chk("nonmono_err",  -1, 256'(obs[0].err), 256'(1));
        chk("nonmono_done", -1, 256'(done_rel),   256'(19));

        // Minimum pacing, nnz = 4.
        for (int j = 0; j < 17; j++) ptr_mem[j] = (j < 4) ? 8'(j) : 8'h04;
        for (int k = 0; k < 4; k++) begin
            val_mem[k] = 16'h5000 + 16'(k);
            col_mem[k] = 4'(2*k + 1);
        end
        run(1, 1'b0);
        chk("e3_done",  -1, 256'(done_rel),     256'(31));
        chk("e3_count", -1, 256'(obs[1].count), 256'(8'd4));
        chk("e3_a",     -1, 256'(obs[1].a),     256'(16'h5003));
        chk("e3_b",     -1, 256'(obs[1].b),     256'(16'h1777));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
